// File: rtl/six_bit_equal_pkg.sv
// -----------------------------------------------------------------------------
// six_bit_equal_pkg
//   Shared definitions for the six-bit equality comparator.
//   CMP_WIDTH  : operand width, fixed at 6
//   operand_t  : packed operand type; bit 5 is the MSB
// -----------------------------------------------------------------------------
package six_bit_equal_pkg;

  localparam int unsigned CMP_WIDTH = 6;

  typedef logic [CMP_WIDTH-1:0] operand_t;

endpackage : six_bit_equal_pkg

// File: rtl/one_bit_equal.sv
// -----------------------------------------------------------------------------
// one_bit_equal
//   Single-bit comparator cell.
//   a, b : input bits
//   eq   : 1 when a == b (XNOR)
//   ne   : 1 when a != b (XOR)
// -----------------------------------------------------------------------------
module one_bit_equal (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic ne
);

  assign ne = a ^ b;
  assign eq = ~ne;

endmodule : one_bit_equal

// File: rtl/six_bit_equal.sv
// -----------------------------------------------------------------------------
// six_bit_equal
//   Compares two 6-bit operands supplied as individual bit ports.
//   clk        : rising-edge clock, used by the registered outputs only
//   rst        : asynchronous active-high reset of the registered outputs
//   a5..a0     : operand A, a5 = MSB
//   b5..b0     : operand B, b5 = MSB
//   equal      : combinational, 1 when A == B
//   diff       : combinational per-bit mismatch, diff[i] = a_i ^ b_i
//   equal_q    : equal sampled on the rising clock edge
//   match_rise : one-cycle registered pulse when equal goes 0 -> 1
// -----------------------------------------------------------------------------
module six_bit_equal
  import six_bit_equal_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       a5,
  input  logic       a4,
  input  logic       a3,
  input  logic       a2,
  input  logic       a1,
  input  logic       a0,
  input  logic       b5,
  input  logic       b4,
  input  logic       b3,
  input  logic       b2,
  input  logic       b1,
  input  logic       b0,
  output logic       equal,
  output logic [5:0] diff,
  output logic       equal_q,
  output logic       match_rise
);

  operand_t a_vec;
  operand_t b_vec;
  operand_t eq_vec;
  operand_t ne_vec;

  assign a_vec = {a5, a4, a3, a2, a1, a0};
  assign b_vec = {b5, b4, b3, b2, b1, b0};

  for (genvar i = 0; i < CMP_WIDTH; i++) begin : g_bit
    one_bit_equal u_bit (
      .a  (a_vec[i]),
      .b  (b_vec[i]),
      .eq (eq_vec[i]),
      .ne (ne_vec[i])
    );
  end

  assign equal = &eq_vec;
  assign diff  = ne_vec;

  logic equal_reg_q, equal_reg_d;
  logic prev_q,      prev_d;
  logic rise_q,      rise_d;

  // prev_q remembers the last sampled equal so a 0 -> 1 edge can be detected;
  // it clears on reset, so a match present at release counts as a rising edge.
  always_comb begin
    equal_reg_d = equal;
    prev_d      = equal;
    rise_d      = equal & ~prev_q;
  end

  // NOTE: the reset branch is in the sensitivity list so the registered
  // outputs clear the moment rst rises, without waiting for a clock edge;
  // all state uses non-blocking assignments so every register samples the
  // pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      equal_reg_q <= 1'b0;
      prev_q      <= 1'b0;
      rise_q      <= 1'b0;
    end else begin
      equal_reg_q <= equal_reg_d;
      prev_q      <= prev_d;
      rise_q      <= rise_d;
    end
  end

  assign equal_q    = equal_reg_q;
  assign match_rise = rise_q;

endmodule : six_bit_equal

// File: tb/tb_six_bit_equal.sv
module tb_six_bit_equal;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] a_v = '0;
  logic [5:0] b_v = '0;
  wire        equal;
  wire  [5:0] diff;
  wire        equal_q;
  wire        match_rise;

  int errors = 0;
  int checks = 0;

  six_bit_equal dut (
    .clk        (clk),
    .rst        (rst),
    .a5         (a_v[5]),
    .a4         (a_v[4]),
    .a3         (a_v[3]),
    .a2         (a_v[2]),
    .a1         (a_v[1]),
    .a0         (a_v[0]),
    .b5         (b_v[5]),
    .b4         (b_v[4]),
    .b3         (b_v[3]),
    .b2         (b_v[2]),
    .b1         (b_v[1]),
    .b0         (b_v[0]),
    .equal      (equal),
    .diff       (diff),
    .equal_q    (equal_q),
    .match_rise (match_rise)
  );

  always #5 clk = ~clk;

  // Reference model: history of "A equals B" as seen at each sampling edge.
  // Reset empties the history down to a single 0 entry.
  bit hist[$] = '{1'b0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete();
      hist.push_back(1'b0);
    end else begin
      hist.push_back(a_v == b_v);
    end
    if (hist.size() > 4) void'(hist.pop_front());
  end

  function automatic bit exp_eq_q();
    return hist[hist.size()-1];
  endfunction

  function automatic bit exp_rise();
    if (hist.size() < 2) return 1'b0;
    return hist[hist.size()-1] && !hist[hist.size()-2];
  endfunction

  task automatic test_reset();
    rst = 1'b1; a_v = '0; b_v = '0;
    repeat (2) @(negedge clk);
    checks++; if (equal_q !== 1'b0) begin errors++; $display("FAIL reset_equal_q: got %b expected 0", equal_q); end
    checks++; if (match_rise !== 1'b0) begin errors++; $display("FAIL reset_match_rise: got %b expected 0", match_rise); end
    checks++; if (equal !== 1'b1) begin errors++; $display("FAIL reset_equal: got %b expected 1", equal); end
    checks++; if (diff !== 6'b0) begin errors++; $display("FAIL reset_diff: got %b expected 000000", diff); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (equal_q !== 1'b1) begin errors++; $display("FAIL release_equal_q: got %b expected 1", equal_q); end
    checks++; if (match_rise !== 1'b1) begin errors++; $display("FAIL release_match_rise: got %b expected 1", match_rise); end
    @(negedge clk);
    checks++; if (match_rise !== 1'b0) begin errors++; $display("FAIL release_rise_once: got %b expected 0", match_rise); end
    checks++; if (equal_q !== 1'b1) begin errors++; $display("FAIL hold_equal_q: got %b expected 1", equal_q); end
  endtask

  task automatic test_single_mismatch();
    logic [5:0] exp_d;
    a_v = 6'b100000; b_v = 6'b000000;
    #1;
    checks++; if (equal !== 1'b0) begin errors++; $display("FAIL msb_equal: got %b expected 0", equal); end
    checks++; if (diff !== 6'b100000) begin errors++; $display("FAIL msb_diff: got %b expected 100000", diff); end
    @(negedge clk);
    checks++; if (equal_q !== 1'b0) begin errors++; $display("FAIL msb_equal_q: got %b expected 0", equal_q); end
    checks++; if (match_rise !== 1'b0) begin errors++; $display("FAIL msb_match_rise: got %b expected 0", match_rise); end
    for (int i = 0; i < 6; i++) begin
      a_v = 6'(1 << i); b_v = '0;
      exp_d = 6'(1 << i);
      #1;
      checks++; if (equal !== 1'b0) begin errors++; $display("FAIL sweep%0d_equal: got %b expected 0", i, equal); end
      checks++; if (diff !== exp_d) begin errors++; $display("FAIL sweep%0d_diff: got %b expected %b", i, diff, exp_d); end
      @(negedge clk);
    end
    a_v = 6'b101010; b_v = 6'b101010;
    #1;
    checks++; if (equal !== 1'b1) begin errors++; $display("FAIL pattern_equal: got %b expected 1", equal); end
    checks++; if (diff !== 6'b0) begin errors++; $display("FAIL pattern_diff: got %b expected 000000", diff); end
    @(negedge clk);
    checks++; if (match_rise !== 1'b1) begin errors++; $display("FAIL pattern_match_rise: got %b expected 1", match_rise); end
  endtask

  // Held in reset so the registers must stay at 0 whatever the operands do.
  task automatic test_exhaustive();
    logic [5:0] exp_d;
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 64; b++) begin
        a_v = 6'(a); b_v = 6'(b);
        exp_d = 6'(a ^ b);
        #1;
        checks++; if (equal !== (a == b)) begin errors++; $display("FAIL exh_equal a=%0d b=%0d: got %b expected %b", a, b, equal, (a == b)); end
        checks++; if (diff !== exp_d) begin errors++; $display("FAIL exh_diff a=%0d b=%0d: got %b expected %b", a, b, diff, exp_d); end
        if (b == 63) begin
          checks++; if (equal_q !== 1'b0 || match_rise !== 1'b0) begin errors++; $display("FAIL exh_regs_in_reset: got equal_q=%b match_rise=%b expected 0 0", equal_q, match_rise); end
        end
      end
    end
  endtask

  task automatic test_toggle();
    int pulses = 0;
    @(negedge clk);
    b_v = 6'b111111; a_v = 6'b111110;
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      checks++; if (equal_q !== exp_eq_q()) begin errors++; $display("FAIL toggle%0d_equal_q: got %b expected %b", k, equal_q, exp_eq_q()); end
      checks++; if (match_rise !== exp_rise()) begin errors++; $display("FAIL toggle%0d_match_rise: got %b expected %b", k, match_rise, exp_rise()); end
      if (match_rise === 1'b1) pulses++;
      a_v = (((k / 3) % 2) == 0) ? 6'b111111 : 6'b111110;
      #1;
      checks++; if (equal !== (a_v == b_v)) begin errors++; $display("FAIL toggle%0d_equal: got %b expected %b", k, equal, (a_v == b_v)); end
    end
    // Matching phases start at k = 0, 6, 12, 18; the last is seen at k = 19.
    checks++; if (pulses != 4) begin errors++; $display("FAIL toggle_pulse_count: got %0d expected 4", pulses); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    a_v = 6'b010101; b_v = 6'b010101;
    repeat (3) @(negedge clk);
    checks++; if (equal_q !== 1'b1) begin errors++; $display("FAIL pre_async_equal_q: got %b expected 1", equal_q); end
    #2 rst = 1'b1;
    #1;
    checks++; if (equal_q !== 1'b0) begin errors++; $display("FAIL async_equal_q: got %b expected 0", equal_q); end
    checks++; if (match_rise !== 1'b0) begin errors++; $display("FAIL async_match_rise: got %b expected 0", match_rise); end
    checks++; if (equal !== 1'b1) begin errors++; $display("FAIL async_equal: got %b expected 1", equal); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (match_rise !== 1'b1) begin errors++; $display("FAIL post_async_match_rise: got %b expected 1", match_rise); end
    checks++; if (equal_q !== 1'b1) begin errors++; $display("FAIL post_async_equal_q: got %b expected 1", equal_q); end
  endtask

  task automatic test_random();
    logic [5:0] ra;
    logic [5:0] rb;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      checks++; if (equal_q !== exp_eq_q()) begin errors++; $display("FAIL rand%0d_equal_q: got %b expected %b", k, equal_q, exp_eq_q()); end
      checks++; if (match_rise !== exp_rise()) begin errors++; $display("FAIL rand%0d_match_rise: got %b expected %b", k, match_rise, exp_rise()); end
      ra = 6'($urandom_range(0, 63));
      rb = ($urandom_range(0, 1) == 1) ? ra : 6'($urandom_range(0, 63));
      a_v = ra; b_v = rb;
      #1;
      checks++; if (equal !== (ra == rb)) begin errors++; $display("FAIL rand%0d_equal: got %b expected %b", k, equal, (ra == rb)); end
      checks++; if (diff !== (ra ^ rb)) begin errors++; $display("FAIL rand%0d_diff: got %b expected %b", k, diff, (ra ^ rb)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_mismatch();
    test_exhaustive();
    test_toggle();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_six_bit_equal
